// File: rtl/draw_rect_layer_engine.sv
// Multi-rectangle overlay: shadow/active slot sets, two-stage hit/priority pipeline.
// Optional blinking slots are built when DRAW_RECT_BLINK_EN is defined.
module draw_rect_layer_engine #(
   parameter int NUM_RECTS    = 4,
   parameter int COORD_W      = 16,
   parameter int COLOR_W      = 12,
   parameter int FB_WIDTH     = 800,
   parameter int ADDR_W       = 19,
   parameter int BLINK_FRAMES = 30,
   localparam int IDX_W       = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [COORD_W-1:0] cfg_x0,
   input  logic [COORD_W-1:0] cfg_y0,
   input  logic [COORD_W-1:0] cfg_x1,
   input  logic [COORD_W-1:0] cfg_y1,
   input  logic [2:0]         cfg_color,
   input  logic               cfg_en,
   input  logic               cfg_blink,
   input  logic               frame_start,
   input  logic               blank,
   input  logic [COORD_W-1:0] h_pos,
   input  logic [COORD_W-1:0] v_pos,
   output logic [ADDR_W-1:0]  addr,
   output logic [COLOR_W-1:0] data_out,
   output logic               hit,
   output logic [IDX_W-1:0]   hit_idx
);
   localparam int FULL_W = COORD_W + 33;

   typedef struct packed {
      logic               en;
      logic               blink;
      logic [2:0]         color;
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
   } slot_t;

   slot_t shadow_q [NUM_RECTS];
   slot_t shadow_d [NUM_RECTS];
   slot_t active_q [NUM_RECTS];
   slot_t active_d [NUM_RECTS];
   logic  rst_state_q;
   logic  cfg_fire;
   slot_t new_slot;

   logic [NUM_RECTS-1:0] slot_vis;
   logic [NUM_RECTS-1:0] slot_hit;
   logic [NUM_RECTS-1:0] hitv1_q, hitv1_d;
   logic [2:0]           col1_q [NUM_RECTS];
   logic [2:0]           col1_d [NUM_RECTS];
   logic [COORD_W-1:0]   h1_q, h1_d, v1_q, v1_d;
   logic                 blank1_q, blank1_d;

   logic [COLOR_W-1:0] data_q, data_d;
   logic               hit_q, hit_d;
   logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;

   // Writes are refused in the commit cycle so a write can never race the copy.
   assign cfg_ready = !rst_state_q && !frame_start;
   assign cfg_fire  = cfg_valid && cfg_ready;

`ifdef DRAW_RECT_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_start) begin
         if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   always_comb begin
      new_slot       = '0;
      new_slot.blink = cfg_blink;
      new_slot.en    = cfg_en;
      new_slot.color = cfg_color;
      new_slot.x0    = cfg_x0;
      new_slot.y0    = cfg_y0;
      new_slot.x1    = cfg_x1;
      new_slot.y1    = cfg_y1;
   end
`else
   localparam int BLINK_FRAMES_UNUSED = BLINK_FRAMES;
   logic blink_unused;
   assign blink_unused = cfg_blink;

   always_comb begin
      new_slot       = '0;
      new_slot.blink = 1'b0;
      new_slot.en    = cfg_en;
      new_slot.color = cfg_color;
      new_slot.x0    = cfg_x0;
      new_slot.y0    = cfg_y0;
      new_slot.x1    = cfg_x1;
      new_slot.y1    = cfg_y1;
   end
`endif

   // Out-of-range cfg_idx matches no slot, so the write is silently dropped.
   always_comb begin
      for (int i = 0; i < NUM_RECTS; i++) begin
         shadow_d[i] = shadow_q[i];
         active_d[i] = frame_start ? shadow_q[i] : active_q[i];
         if (cfg_fire && (cfg_idx == IDX_W'(i)))
            shadow_d[i] = new_slot;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RECTS; gi++) begin : g_slot
`ifdef DRAW_RECT_BLINK_EN
         assign slot_vis[gi] = active_q[gi].en && !(active_q[gi].blink && blink_phase_q);
`else
         assign slot_vis[gi] = active_q[gi].en && !active_q[gi].blink;
`endif
         assign slot_hit[gi] = slot_vis[gi]
                               && (h_pos >= active_q[gi].x0) && (h_pos <= active_q[gi].x1)
                               && (v_pos >= active_q[gi].y0) && (v_pos <= active_q[gi].y1);
      end
   endgenerate

   always_comb begin
      hitv1_d  = slot_hit;
      h1_d     = h_pos;
      v1_d     = v_pos;
      blank1_d = blank;
      for (int i = 0; i < NUM_RECTS; i++)
         col1_d[i] = active_q[i].color;
   end

   function automatic logic [COLOR_W-1:0] palette(input logic [2:0] c);
      logic [11:0]        p;
      logic [COLOR_W-1:0] o;
      case (c)
         3'd1:    p = 12'hF00;
         3'd2:    p = 12'h0F0;
         3'd3:    p = 12'h00F;
         3'd4:    p = 12'hFFF;
         default: p = 12'h000;
      endcase
      o = '0;
      for (int k = 0; k < COLOR_W; k++)
         o[COLOR_W-1-k] = p[11 - ((k * 12) / COLOR_W)];
      return o;
   endfunction

   // Scan from the top so the lowest set index is the one left standing.
   always_comb begin
      logic             win;
      logic [IDX_W-1:0] widx;
      logic [2:0]       wcol;
      win  = 1'b0;
      widx = '0;
      wcol = '0;
      for (int i = NUM_RECTS - 1; i >= 0; i--) begin
         if (hitv1_q[i]) begin
            win  = 1'b1;
            widx = IDX_W'(i);
            wcol = col1_q[i];
         end
      end
      hit_d     = win && !blank1_q;
      hit_idx_d = hit_d ? widx : '0;
      data_d    = hit_d ? palette(wcol) : '0;
      addr_d    = ADDR_W'(FULL_W'(v1_q) * FULL_W'(FB_WIDTH) + FULL_W'(h1_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_state_q <= 1'b1;
         for (int i = 0; i < NUM_RECTS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
            col1_q[i]   <= '0;
         end
         hitv1_q   <= '0;
         h1_q      <= '0;
         v1_q      <= '0;
         blank1_q  <= 1'b0;
         data_q    <= '0;
         hit_q     <= 1'b0;
         hit_idx_q <= '0;
         addr_q    <= '0;
      end else begin
         rst_state_q <= 1'b0;
         for (int i = 0; i < NUM_RECTS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
            col1_q[i]   <= col1_d[i];
         end
         hitv1_q   <= hitv1_d;
         h1_q      <= h1_d;
         v1_q      <= v1_d;
         blank1_q  <= blank1_d;
         data_q    <= data_d;
         hit_q     <= hit_d;
         hit_idx_q <= hit_idx_d;
         addr_q    <= addr_d;
      end
   end

   assign data_out = data_q;
   assign hit      = hit_q;
   assign hit_idx  = hit_idx_q;
   assign addr     = addr_q;
endmodule

// File: tb/tb_draw_rect_layer_engine.sv
// Scoreboard bench for draw_rect_layer_engine (default build, blink feature off).
module tb_draw_rect_layer_engine;
   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid, cfg_ready;
   logic [1:0]  cfg_idx;
   logic [15:0] cfg_x0, cfg_y0, cfg_x1, cfg_y1;
   logic [2:0]  cfg_color;
   logic        cfg_en, cfg_blink;
   logic        frame_start, blank;
   logic [15:0] h_pos, v_pos;
   logic [18:0] addr;
   logic [11:0] data_out;
   logic        hit;
   logic [1:0]  hit_idx;

   always #5 clk = ~clk;

   draw_rect_layer_engine #(
      .NUM_RECTS(4), .COORD_W(16), .COLOR_W(12), .FB_WIDTH(800), .ADDR_W(19), .BLINK_FRAMES(30)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_x1(cfg_x1), .cfg_y1(cfg_y1),
      .cfg_color(cfg_color), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
      .frame_start(frame_start), .blank(blank), .h_pos(h_pos), .v_pos(v_pos),
      .addr(addr), .data_out(data_out), .hit(hit), .hit_idx(hit_idx)
   );

   typedef struct {
      bit en;
      int x0, y0, x1, y1, col;
   } rect_t;

   typedef struct {
      int          due;
      int          h, v;
      logic [11:0] d;
      logic        ht;
      logic [1:0]  idx;
      logic [18:0] a;
   } exp_t;

   rect_t sh_m [4];
   rect_t ac_m [4];
   exp_t  q[$];
   int    cyc = 0;
   int    vectors_applied = 0;
   int    miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors_applied++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic bound_fail(input string tag);
      vectors_applied++;
      miscompares++;
      $display("FAIL %s got=timeout expected=event", tag);
   endtask

   function automatic logic [11:0] pal(input int c);
      case (c)
         1: return 12'hF00;
         2: return 12'h0F0;
         3: return 12'h00F;
         4: return 12'hFFF;
         default: return 12'h000;
      endcase
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         sh_m[i] = '{0, 0, 0, 0, 0, 0};
         ac_m[i] = '{0, 0, 0, 0, 0, 0};
      end
   endtask

   task automatic pixel(input int h, input int v, input bit b);
      exp_t e;
      int   win;
      @(posedge clk);
      #1;
      h_pos = 16'(h);
      v_pos = 16'(v);
      blank = b;
      win = -1;
      for (int i = 0; i < 4; i++)
         if (win < 0 && ac_m[i].en && ac_m[i].x0 <= h && h <= ac_m[i].x1
             && ac_m[i].y0 <= v && v <= ac_m[i].y1)
            win = i;
      e.due = cyc + 2;
      e.h   = h;
      e.v   = v;
      e.a   = 19'((v * 800 + h) % 524288);
      if (b || win < 0) begin
         e.d = 12'h000; e.ht = 1'b0; e.idx = 2'd0;
      end else begin
         e.d = pal(ac_m[win].col); e.ht = 1'b1; e.idx = 2'(win);
      end
      q.push_back(e);
   endtask

   task automatic cfg_write(input int idx, input int x0, input int y0, input int x1,
                            input int y1, input int col, input bit en);
      bit ok;
      @(posedge clk);
      #1;
      cfg_idx = 2'(idx); cfg_x0 = 16'(x0); cfg_y0 = 16'(y0); cfg_x1 = 16'(x1); cfg_y1 = 16'(y1);
      cfg_color = 3'(col); cfg_en = en; cfg_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (cfg_ready) ok = 1;
         @(posedge clk);
      end
      if (ok) sh_m[idx] = '{en, x0, y0, x1, y1, col};
      else bound_fail("cfg_handshake");
      #1 cfg_valid = 1'b0;
   endtask

   task automatic frame();
      @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) ac_m[i] = sh_m[i];
      #1 frame_start = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && q.size() > 0) begin
         if (q[0].due < cyc) begin
            void'(q.pop_front());
            bound_fail("pixel_slot");
         end else if (q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            $display("pix (%0d,%0d) blank=%b -> data=%h hit=%b idx=%0d addr=%0d",
                     e.h, e.v, blank, data_out, hit, hit_idx, addr);
            check_val("pix_data", 32'(data_out), 32'(e.d));
            check_val("pix_hit", 32'(hit), 32'(e.ht));
            check_val("pix_idx", 32'(hit_idx), 32'(e.idx));
            check_val("pix_addr", 32'(addr), 32'(e.a));
         end
      end
   end

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_x0 = '0; cfg_y0 = '0; cfg_x1 = '0;
      cfg_y1 = '0; cfg_color = '0; cfg_en = 1'b0; cfg_blink = 1'b0; frame_start = 1'b0;
      blank = 1'b0; h_pos = '0; v_pos = '0;
      clear_model();

      // Reset state and cfg_ready release timing
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_data", 32'(data_out), 0);
      check_val("rst_hit", 32'(hit), 0);
      check_val("rst_idx", 32'(hit_idx), 0);
      check_val("rst_addr", 32'(addr), 0);
      check_val("rst_ready", 32'(cfg_ready), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("ready_before_clk", 32'(cfg_ready), 0);
      @(posedge clk);
      #1 check_val("ready_after_clk", 32'(cfg_ready), 1);

      // Single rectangle
      cfg_write(0, 144, 35, 200, 60, 1, 1);
      pixel(144, 35, 0);
      frame();
      pixel(144, 35, 0);
      pixel(201, 35, 0);
      pixel(200, 60, 0);
      pixel(143, 35, 0);

      // Overlap priority
      cfg_write(0, 250, 80, 350, 120, 3, 1);
      cfg_write(2, 290, 90, 400, 200, 4, 1);
      frame();
      pixel(300, 100, 0);
      cfg_write(0, 250, 80, 350, 120, 3, 0);
      pixel(300, 100, 0);
      frame();
      pixel(300, 100, 0);

      // Write collides with commit: stalls one cycle, lands in the next frame
      @(posedge clk);
      #1;
      cfg_idx = 2'd1; cfg_x0 = 16'd0; cfg_y0 = 16'd0; cfg_x1 = 16'd10; cfg_y1 = 16'd10;
      cfg_color = 3'd2; cfg_en = 1'b1; cfg_valid = 1'b1; frame_start = 1'b1;
      @(negedge clk);
      check_val("ready_in_commit", 32'(cfg_ready), 0);
      @(posedge clk);
      for (int i = 0; i < 4; i++) ac_m[i] = sh_m[i];
      #1 frame_start = 1'b0;
      @(negedge clk);
      check_val("ready_after_commit", 32'(cfg_ready), 1);
      @(posedge clk);
      sh_m[1] = '{1, 0, 0, 10, 10, 2};
      #1 cfg_valid = 1'b0;
      pixel(5, 5, 0);
      frame();
      pixel(5, 5, 0);

      // Boundaries: single-point slot, degenerate slot, blank, black palette entry, wrap
      cfg_write(3, 500, 500, 500, 500, 1, 1);
      frame();
      pixel(500, 500, 0);
      pixel(501, 500, 0);
      pixel(499, 500, 0);
      pixel(500, 501, 0);
      cfg_write(3, 10, 0, 5, 20, 2, 1);
      frame();
      pixel(7, 15, 0);
      pixel(10, 15, 0);
      pixel(5, 15, 0);
      pixel(300, 100, 1);
      cfg_write(1, 0, 0, 10, 10, 6, 1);
      frame();
      pixel(5, 5, 0);
      pixel(799, 700, 0);

      // Random pixels over several overlapping slots
      cfg_write(0, 100, 100, 300, 300, 1, 1);
      cfg_write(1, 200, 200, 400, 400, 2, 1);
      cfg_write(2, 50, 250, 500, 260, 3, 1);
      cfg_write(3, 0, 0, 599, 599, 4, 1);
      frame();
      for (int n = 0; n < 40; n++)
         pixel(int'($urandom_range(0, 620)), int'($urandom_range(0, 620)), bit'($urandom_range(0, 7) == 0));

      // Asynchronous reset mid-stream
      pixel(150, 150, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      check_val("pre_rst_hit", 32'(hit), 1);
      q.delete();
      rst = 1'b1;
      #1;
      check_val("mid_rst_data", 32'(data_out), 0);
      check_val("mid_rst_hit", 32'(hit), 0);
      check_val("mid_rst_addr", 32'(addr), 0);
      check_val("mid_rst_ready", 32'(cfg_ready), 0);
      clear_model();
      @(posedge clk);
      #1 rst = 1'b0;
      pixel(150, 150, 0);
      frame();
      pixel(150, 150, 0);

      repeat (4) @(posedge clk);
      #1;
      if (q.size() != 0) bound_fail("scoreboard_drain");
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end
endmodule

// File: doc/draw_rect_layer_engine.md
# draw_rect_layer_engine

Parametrised multi-rectangle overlay engine for the VGA draw path. It holds NUM_RECTS independently configured rectangles in shadow registers, loaded through a valid/ready port. The shadow set commits atomically to the active set at frame start. For each incoming beam position it resolves the highest-priority covering rectangle and emits a palette colour plus the matching frame-buffer address, both pipeline-aligned.

## Interface
- NUM_RECTS, 4, number of rectangle slots (1..16)
- COORD_W, 16, width of every coordinate
- COLOR_W, 12, output pixel width (RGB 4:4:4 at 12)
- FB_WIDTH, 800, line pitch used for address calculation
- ADDR_W, 19, frame-buffer address width
- BLINK_FRAMES, 30, frames per blink half-period (blink build only)

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  config write request
- cfg_ready  out  1  engine can accept a config write this cycle
- cfg_idx  in  $clog2(NUM_RECTS) (min 1)  target slot
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  COORD_W each  inclusive bounds
- cfg_color  in  3  palette index
- cfg_en  in  1  slot enable
- cfg_blink  in  1  slot blinks (ignored unless blink build)
- frame_start  in  1  one-cycle pulse at start of frame
- blank  in  1  high = outside visible area, force black
- h_pos, v_pos  in  COORD_W each  current beam position
- addr  out  ADDR_W  frame-buffer address aligned with data_out
- data_out  out  COLOR_W  pixel colour
- hit  out  1  some rectangle covers the aligned pixel
- hit_idx  out  $clog2(NUM_RECTS) (min 1)  winning slot, 0 when !hit

## Operation
- Config write: the handshake fires when cfg_valid && cfg_ready. The write updates shadow slot cfg_idx with all fields. cfg_idx >= NUM_RECTS is accepted and discarded.
- cfg_ready = !rst_state && !commit. It is low in the cycle frame_start is high. A write presented that cycle stalls to the next cycle and lands in the following frame.
- Commit: on frame_start, active[i] <= shadow[i] for all i in one cycle. Shadow writes are never visible mid-frame.
- Hit test per slot: en && x0<=h_pos<=x1 && y0<=v_pos<=y1 (unsigned). Degenerate slots (x0>x1 or y0>y1) never hit.
- Priority: the lowest index wins.
- Palette: 0 black 12'h000, 1 red 12'hF00, 2 green 12'h0F0, 3 blue 12'h00F, 4 white 12'hFFF, 5..7 black. For COLOR_W != 12 the value is replicated/truncated per channel MSB-first.
- Output: blank=1 or no hit gives data_out=0, hit=0, hit_idx=0.
- Address: v_pos*FB_WIDTH + h_pos computed at full width then truncated to ADDR_W. Wrap is silent.

## Timing
- Pipeline: stage 1 registers per-slot hit vector, position, and blank. Stage 2 registers the priority-encoded colour, hit, hit_idx, and addr.
- Latency from h_pos/v_pos/blank to data_out/addr/hit is 2 cycles. Throughput is one pixel per cycle with no stalls.
- A commit on frame_start at cycle t affects the pixel sampled at t+1 (output at t+3).
- Reset values: data_out=0, addr=0, hit=0, hit_idx=0, cfg_ready=0.
  - cfg_ready rises on the first clk after rst deasserts.
  - All shadow and active slots clear to en=0, coords 0, colour 0.
  - The blink counter and phase clear to 0.
- Reset mid-frame clears the pipeline. An in-flight config write is lost.
- rst has priority over frame_start and cfg_valid.

## Configuration
- Macro: DRAW_RECT_BLINK_EN.
- Defined:
  - A frame counter increments on each frame_start. It wraps at BLINK_FRAMES-1 and toggles blink_phase.
  - A slot with blink=1 is treated as disabled while blink_phase=1.
  - The counter and phase are reset to 0 by rst.
- Undefined: the counter and phase are not built, cfg_blink is ignored, and all enabled slots are always visible.

## Test plan
- Reset then idle:
  - Assert rst mid-stream -> all outputs 0 immediately.
  - cfg_ready=0 until the first clk after release, then 1.
- Single rectangle:
  - Write slot 0 (x0=144, y0=35, x1=200, y1=60, color=1, en=1), then pulse frame_start.
  - Drive h=144, v=35 -> two cycles later data_out=12'hF00, hit=1, hit_idx=0, addr=28144.
  - h=201 -> data_out=0.
- Overlap priority:
  - Slot 0 blue and slot 2 white both cover (300,100) -> data_out=12'h00F, hit_idx=0.
  - Disable slot 0 and commit -> data_out=12'hFFF, hit_idx=2.
- Shadow/commit collision:
  - Hold cfg_valid in the same cycle as frame_start -> cfg_ready=0 that cycle, write accepted next cycle.
  - The change appears only after the next frame_start.
- Boundaries:
  - x0=x1=y0=y1=500 hits exactly (500,500) only.
  - x0=10, x1=5 never hits.
  - blank=1 inside a rectangle -> data_out=0.
  - color=6 -> black with hit=1.
- Blink (with DRAW_RECT_BLINK_EN, BLINK_FRAMES=2):
  - Slot with blink=1 is visible for frames 0-1, hidden for frames 2-3, visible for frames 4-5.
  - Without the macro it is always visible.
